// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-side bridge.
package slc3_mem_pkg;

  localparam logic [15:0] MMIO_SW_HEX_ADDR     = 16'hFFFF;
  localparam int          MEM_READ_LAT_DEFAULT = 2;

  // One read-pipeline stage: which address it tracks, whether the read is
  // still live, and (for the switch port) the data captured at issue time.
  typedef struct packed {
    logic [15:0] addr;
    logic        valid;
    logic        is_io;
    logic [15:0] io_data;
  } mem_pipe_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs (switches).
module sync_2ff #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second settles.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-side bridge between SLC-3 control/datapath and a registered BRAM.
// Tracks read latency with a tagged address pipeline so mem_rdy only fires
// for data that belongs to the current MAR. Define MEM_IO_MMIO_EN to map
// switches (read) and the hex display register (write) at xFFFF.
module mem_io_bridge
  import slc3_mem_pkg::*;
#(
  parameter int READ_LAT = MEM_READ_LAT_DEFAULT,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_mem_ena,
  input  logic              mem_wr_ena,
  input  logic [15:0]       mar,
  input  logic [15:0]       mdr,
  input  logic [15:0]       sw_i,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_din,
  output logic              bram_we,
  input  logic [15:0]       bram_dout,
  output logic [15:0]       mem_rdata,
  output logic              mem_rdy,
  output logic [15:0]       hex_out
);

  logic        rd_req, wr_req, is_mmio;
  logic [15:0] sw_sync;
  mem_pipe_t   pipe [READ_LAT];
  mem_pipe_t   last;

  assign rd_req = mem_mem_ena & ~mem_wr_ena;
  assign wr_req = mem_mem_ena &  mem_wr_ena;

`ifdef MEM_IO_MMIO_EN
  assign is_mmio = (mar == MMIO_SW_HEX_ADDR);

  sync_2ff #(.W(16)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_i),
    .q     (sw_sync)
  );

  // Hex display register; MMIO writes land here instead of the BRAM.
  always_ff @(posedge clk) begin
    if (reset)                 hex_out <= '0;
    else if (wr_req && is_mmio) hex_out <= mdr;
  end
`else
  logic unused_sw;
  assign unused_sw = ^sw_i;
  assign is_mmio   = 1'b0;
  assign sw_sync   = '0;
  assign hex_out   = '0;
`endif

  // Read tracking pipeline. A write invalidates any in-flight read of the
  // same address as it advances, so a later read waits a full READ_LAT and
  // never returns pre-write data. Stage 0 never loads valid on a write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0].addr    <= mar;
      pipe[0].valid   <= rd_req;
      pipe[0].is_io   <= is_mmio;
      pipe[0].io_data <= sw_sync;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe[i] <= pipe[i-1];
        if (wr_req && (pipe[i-1].addr == mar)) pipe[i].valid <= 1'b0;
      end
    end
  end

  assign last      = pipe[READ_LAT-1];
  assign bram_addr = mar[ADDR_W-1:0];
  assign bram_din  = mdr;
  assign bram_we   = ~reset & wr_req & ~is_mmio;
  assign mem_rdata = !last.valid ? 16'h0000 :
                     last.is_io  ? last.io_data : bram_dout;
  assign mem_rdy   = last.valid & (last.addr == mar) & mem_mem_ena;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a 2-cycle registered BRAM model.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset, mem_mem_ena, mem_wr_ena;
  logic [15:0] mar, mdr, sw_i;
  logic [15:0] bram_addr, bram_din, bram_dout, mem_rdata, hex_out;
  logic        bram_we, mem_rdy;

  int checks = 0;
  int failures = 0;

  // BRAM model: address register then output register (latency 2).
  logic [15:0] mem [0:65535];
  logic [15:0] bram_aq;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0, pre_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)  mem[pre_addr]  <= pre_data;
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_aq   <= bram_addr;
    bram_dout <= mem[bram_aq];
  end

  mem_io_bridge #(.READ_LAT(2), .ADDR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_mem_ena (mem_mem_ena),
    .mem_wr_ena  (mem_wr_ena),
    .mar         (mar),
    .mdr         (mdr),
    .sw_i        (sw_i),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .bram_we     (bram_we),
    .bram_dout   (bram_dout),
    .mem_rdata   (mem_rdata),
    .mem_rdy     (mem_rdy),
    .hex_out     (hex_out)
  );

`ifdef MEM_IO_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs sampled at the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input logic ena, input logic wr, input logic [15:0] a, input logic [15:0] d);
    mem_mem_ena = ena;
    mem_wr_ena  = wr;
    mar         = a;
    mdr         = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    nxt();
    pre_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (n) nxt();
  endtask

  initial begin
    reset = 1'b1;
    sw_i  = 16'h00F3;
    // Write strobe held during reset must not reach the BRAM.
    drv(1'b1, 1'b1, 16'h3010, 16'hDEAD);
    nxt();
    preload(16'h3000, 16'h1234);
    preload(16'h3001, 16'hBEEF);
    preload(16'h3004, 16'h1111);
    preload(16'hFFFF, 16'h7777);
    smp();
    chk("rst_rdy",   {15'd0, mem_rdy}, 16'h0000);
    chk("rst_rdata", mem_rdata,        16'h0000);
    chk("rst_we",    {15'd0, bram_we}, 16'h0000);
    chk("rst_hex",   hex_out,          16'h0000);
    nxt();
    reset = 1'b0;

    // Basic read latency on x3000.
    drv(1'b1, 1'b0, 16'h3000, 16'h0000);
    smp(); chk("rd_c0_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("rd_c1_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("rd_c2_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("rd_c2_dat", mem_rdata,        16'h1234); nxt();
    smp(); chk("rd_c3_rdy", {15'd0, mem_rdy}, 16'h0001); nxt();

    // Address change mid-read: old data never flagged ready.
    idle(3);
    drv(1'b1, 1'b0, 16'h3000, 16'h0000); nxt();
    mar = 16'h3001;
    smp(); chk("chg_c1_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("chg_c2_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("chg_c3_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("chg_c3_dat", mem_rdata,        16'hBEEF); nxt();

    // Held write then read back.
    idle(2);
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b1, 16'h3002, 16'h5555);
      smp(); chk("wr_we", {15'd0, bram_we}, 16'h0001); nxt();
    end
    drv(1'b1, 1'b0, 16'h3002, 16'h0000);
    smp(); chk("wr_rd_we",  {15'd0, bram_we}, 16'h0000);
           chk("wr_rd_c0",  {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("wr_rd_c1",  {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("wr_rd_c2",  {15'd0, mem_rdy}, 16'h0001);
           chk("wr_rd_dat", mem_rdata,        16'h5555); nxt();

    // Write hazard: read in flight, write same address, resume read.
    idle(3);
    drv(1'b1, 1'b0, 16'h3004, 16'h0000); nxt();
    drv(1'b1, 1'b1, 16'h3004, 16'h0A0A);
    smp(); chk("hz_wr_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    drv(1'b1, 1'b0, 16'h3004, 16'h0000);
    smp(); chk("hz_c2_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("hz_c3_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("hz_c4_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("hz_c4_dat", mem_rdata,        16'h0A0A); nxt();

    // xFFFF: switches/hex when MMIO is built in, plain BRAM otherwise.
    idle(2);
    drv(1'b1, 1'b0, 16'hFFFF, 16'h0000); nxt(); nxt();
    smp(); chk("io_rd_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("io_rd_dat", mem_rdata, MMIO ? 16'h00F3 : 16'h7777); nxt();
    drv(1'b1, 1'b1, 16'hFFFF, 16'hC0DE);
    smp(); chk("io_wr_we", {15'd0, bram_we}, MMIO ? 16'h0000 : 16'h0001); nxt();
    drv(1'b1, 1'b0, 16'hFFFF, 16'h0000);
    smp(); chk("io_hex",    hex_out,          MMIO ? 16'hC0DE : 16'h0000);
           chk("io_rd2_we", {15'd0, bram_we}, 16'h0000); nxt(); nxt();
    smp(); chk("io_rd2_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("io_rd2_dat", mem_rdata, MMIO ? 16'h00F3 : 16'hC0DE); nxt();

    // Reset in the middle of a read drops it; restarted read needs full latency.
    idle(2);
    drv(1'b1, 1'b0, 16'h3000, 16'h0000); nxt(); nxt();
    smp(); chk("rr_pre_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("rr_pre_hex", hex_out, MMIO ? 16'hC0DE : 16'h0000); nxt();
    reset = 1'b1; nxt();
    reset = 1'b0;
    smp(); chk("rr_c0_rdy", {15'd0, mem_rdy}, 16'h0000);
           chk("rr_c0_hex", hex_out,          16'h0000); nxt();
    smp(); chk("rr_c1_rdy", {15'd0, mem_rdy}, 16'h0000); nxt();
    smp(); chk("rr_c2_rdy", {15'd0, mem_rdy}, 16'h0001);
           chk("rr_c2_dat", mem_rdata,        16'h1234); nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
